// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control path.
//   - memState_t   : memory responder FSM states
//   - OP_*         : opcode constants used by the control path
//   - WORD_BYTES   : bytes per machine word
package mc_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } memState_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/mc_mem_array.sv
// Single-port synchronous word RAM (DATA_W x 2^DEPTH_LOG2).
// Ports:
//   clk    : clock
//   reset  : synchronous active-high reset; clears only the read register, not the RAM
//   we     : write enable, writes wdata to mem[addr] on the rising edge
//   re     : read enable, loads rdata from mem[addr] on the rising edge
//   addr   : word index
//   wdata  : write data
//   rdata  : registered read data, holds its value while re is low
module mc_mem_array #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rdataQ;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdataQ <= '0;
    end else if (re) begin
      rdataQ <= mem[addr];
    end
  end

  assign rdata = rdataQ;

endmodule

// File: rtl/mc_mem_responder.sv
// Memory-side responder for the multicycle MIPS control path. Accepts a held
// MemRead/MemWrite request, waits WAIT_STATES cycles, then pulses MemReady for one cycle.
// Optional build macro: MC_MEM_MISALIGN_CHECK_EN adds MemFault and suppresses
// misaligned accesses (Addr[1:0] != 0).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   MemRead    : read request, held until MemReady
//   MemWrite   : write request, held until MemReady (wins when both are high)
//   Addr       : byte address; word index is Addr[DEPTH_LOG2+1:2], upper bits wrap
//   WriteData  : store data
//   ReadData   : last read result, valid while MemReady for reads
//   MemReady   : one-cycle completion pulse
//   MemBusy    : access accepted and still waiting
//   MemFault   : (macro only) misaligned access, coincident with MemReady
module mc_mem_responder
  import mc_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
`ifdef MC_MEM_MISALIGN_CHECK_EN
  output logic              MemFault,
`endif
  output logic              MemReady,
  output logic              MemBusy
);

  localparam int unsigned ByteBits = $clog2(WORD_BYTES);
  localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

  memState_t stateQ, stateD;
  logic [3:0] waitCntQ, waitCntD;
  logic latchReq;

  logic                  opWriteQ;
  logic                  misalignQ;
  logic [DEPTH_LOG2-1:0] idxQ;
  logic [DATA_W-1:0]     wdataQ;

  logic [DEPTH_LOG2-1:0] addrIdx;
  logic                  misalignNow;
  logic                  ramWe, ramRe;
  logic [DEPTH_LOG2-1:0] ramAddr;

  assign addrIdx = Addr[DEPTH_LOG2+ByteBits-1:ByteBits];

`ifdef MC_MEM_MISALIGN_CHECK_EN
  assign misalignNow = |Addr[1:0];
`else
  assign misalignNow = 1'b0;
`endif

  // Upper address bits are deliberately ignored (address wraps).
  logic unusedAddr;
  assign unusedAddr = ^{Addr[31:DEPTH_LOG2+ByteBits], Addr[ByteBits-1:0]};

  always_comb begin
    stateD   = stateQ;
    waitCntD = waitCntQ;
    latchReq = 1'b0;
    case (stateQ)
      MEM_IDLE: begin
        if (MemRead || MemWrite) begin
          latchReq = 1'b1;
          waitCntD = WaitInit;
          stateD   = (WAIT_STATES > 0) ? MEM_WAIT : MEM_DONE;
        end
      end
      MEM_WAIT: begin
        waitCntD = waitCntQ - 4'd1;
        if (waitCntQ <= 4'd1) begin
          stateD = MEM_DONE;
        end
      end
      MEM_DONE: stateD = MEM_IDLE;
      default:  stateD = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= MEM_IDLE;
      waitCntQ  <= '0;
      opWriteQ  <= 1'b0;
      misalignQ <= 1'b0;
      idxQ      <= '0;
      wdataQ    <= '0;
    end else begin
      stateQ   <= stateD;
      waitCntQ <= waitCntD;
      if (latchReq) begin
        opWriteQ  <= MemWrite;
        misalignQ <= misalignNow;
        idxQ      <= addrIdx;
        wdataQ    <= WriteData;
      end
    end
  end

  // With zero wait states DONE is entered straight from IDLE, before the index latch
  // has loaded, so the RAM is addressed from the live request in IDLE.
  assign ramAddr = (stateQ == MEM_IDLE) ? addrIdx : idxQ;

  // Read lands in the RAM output register on the edge entering DONE.
  always_comb begin
    ramRe = 1'b0;
    if (stateD == MEM_DONE) begin
      if (stateQ == MEM_IDLE) begin
        ramRe = MemRead && !MemWrite && !misalignNow;
      end else if (stateQ == MEM_WAIT) begin
        ramRe = !opWriteQ && !misalignQ;
      end
    end
  end

  // Write commits on the edge leaving DONE; reset abandons it.
  assign ramWe = (stateQ == MEM_DONE) && opWriteQ && !misalignQ && !reset;

  mc_mem_array #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) uArray (
    .clk  (clk),
    .reset(reset),
    .we   (ramWe),
    .re   (ramRe),
    .addr (ramAddr),
    .wdata(wdataQ),
    .rdata(ReadData)
  );

  assign MemReady = (stateQ == MEM_DONE);
  assign MemBusy  = (stateQ == MEM_WAIT);

`ifdef MC_MEM_MISALIGN_CHECK_EN
  assign MemFault = (stateQ == MEM_DONE) && misalignQ;
`endif

endmodule

// File: tb/tb_mc_mem_responder.sv
module tb_mc_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] Addr, WriteData, ReadData;
  logic        MemReady, MemBusy;

  logic        rd1;
  logic [31:0] addr1, wd1, rdata1;
  logic        ready1, busy1;

`ifdef MC_MEM_MISALIGN_CHECK_EN
  logic MemFault, fault1;
`endif

  int total = 0;
  int bad   = 0;
  logic faultSeen;

  always #5 clk = ~clk;

  mc_mem_responder #(.DATA_W(32), .DEPTH_LOG2(8), .WAIT_STATES(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .Addr     (Addr),
    .WriteData(WriteData),
    .ReadData (ReadData),
`ifdef MC_MEM_MISALIGN_CHECK_EN
    .MemFault (MemFault),
`endif
    .MemReady (MemReady),
    .MemBusy  (MemBusy)
  );

  mc_mem_responder #(.DATA_W(32), .DEPTH_LOG2(8), .WAIT_STATES(0)) dut0 (
    .clk      (clk),
    .reset    (reset),
    .MemRead  (rd1),
    .MemWrite (1'b0),
    .Addr     (addr1),
    .WriteData(wd1),
    .ReadData (rdata1),
`ifdef MC_MEM_MISALIGN_CHECK_EN
    .MemFault (fault1),
`endif
    .MemReady (ready1),
    .MemBusy  (busy1)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one access from IDLE, wait (bounded) for MemReady, drop the request and
  // step one more edge so a write has committed. Expected latency is WAIT_STATES+1 edges.
  task automatic doAccess(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] expRdDone);
    int   n;
    logic seen;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Addr = a; WriteData = wd;
    n = 0; seen = 1'b0; faultSeen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (MemReady) seen = 1'b1;
    end
    checkEq("ready_seen", 32'(seen), 32'd1);
    checkEq("latency", 32'(n), 32'd3);
    checkEq("rdata_at_ready", ReadData, expRdDone);
`ifdef MC_MEM_MISALIGN_CHECK_EN
    faultSeen = MemFault;
`endif
    MemRead = 1'b0; MemWrite = 1'b0;
    @(posedge clk); #1;
    checkEq("ready_one_cycle", 32'(MemReady), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; Addr = '0; WriteData = '0;
    rd1 = 1'b0; addr1 = '0; wd1 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkEq("rst_rdata", ReadData, 32'h0);
    checkEq("rst_ready", 32'(MemReady), 32'd0);
    checkEq("rst_busy", 32'(MemBusy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Preload RAM[4] and RAM[16].
    doAccess(1'b0, 1'b1, 32'h10, 32'h8C020010, 32'h0);
    doAccess(1'b0, 1'b1, 32'h40, 32'h0, 32'h0);

    // Cycle-accurate read of 0x10.
    @(negedge clk);
    MemRead = 1'b1; Addr = 32'h10;
    @(posedge clk); #1;
    checkEq("c1_busy", 32'(MemBusy), 32'd1);
    checkEq("c1_ready", 32'(MemReady), 32'd0);
    @(posedge clk); #1;
    checkEq("c2_busy", 32'(MemBusy), 32'd1);
    checkEq("c2_ready", 32'(MemReady), 32'd0);
    @(posedge clk); #1;
    checkEq("c3_busy", 32'(MemBusy), 32'd0);
    checkEq("c3_ready", 32'(MemReady), 32'd1);
    checkEq("c3_rdata", ReadData, 32'h8C020010);
    MemRead = 1'b0;
    @(posedge clk); #1;
    checkEq("c4_ready", 32'(MemReady), 32'd0);

    // Write leaves ReadData alone; read back.
    doAccess(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 32'h8C020010);
    checkEq("wr_rdata_hold", ReadData, 32'h8C020010);
    doAccess(1'b1, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF);

    // Both high is a write; ReadData keeps prior value.
    doAccess(1'b1, 1'b1, 32'h0, 32'h1234, 32'hDEADBEEF);
    doAccess(1'b1, 1'b0, 32'h0, 32'h0, 32'h1234);

    // Address wrap: 0x410 aliases word 4.
    doAccess(1'b1, 1'b0, 32'h410, 32'h0, 32'h8C020010);

    // Reset during WAIT of a write abandons it.
    @(negedge clk);
    MemWrite = 1'b1; Addr = 32'h40; WriteData = 32'hFFFFFFFF;
    @(posedge clk); #1;
    checkEq("mid_busy", 32'(MemBusy), 32'd1);
    @(negedge clk);
    reset = 1'b1; MemWrite = 1'b0;
    @(posedge clk); #1;
    checkEq("mid_ready", 32'(MemReady), 32'd0);
    checkEq("mid_busy0", 32'(MemBusy), 32'd0);
    checkEq("mid_rdata", ReadData, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checkEq("mid_no_ready", 32'(MemReady), 32'd0);
    doAccess(1'b1, 1'b0, 32'h40, 32'h0, 32'h0);
    doAccess(1'b1, 1'b0, 32'h10, 32'h0, 32'h8C020010);

`ifdef MC_MEM_MISALIGN_CHECK_EN
    doAccess(1'b0, 1'b1, 32'h22, 32'h55555555, 32'h8C020010);
    checkEq("mis_fault", 32'(faultSeen), 32'd1);
    doAccess(1'b1, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF);
    checkEq("aligned_nofault", 32'(faultSeen), 32'd0);
`endif

    // Zero wait states, MemRead held: MemReady alternates, never back to back.
    @(negedge clk);
    rd1 = 1'b1; addr1 = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      checkEq($sformatf("b2b_ready_%0d", k), 32'(ready1), 32'(k % 2));
      checkEq($sformatf("b2b_busy_%0d", k), 32'(busy1), 32'd0);
    end
    rd1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
